// File: rtl/addsub_pkg.sv
// Shared types and constants for the multi-byte add/subtract sequencer.
package addsub_pkg;

    localparam int MAX_BYTES = 8;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_byte_buf.sv
// Small byte-wide register file: one write port, one combinational read port,
// every entry cleared by the asynchronous reset.
module addsub_byte_buf #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [2:0] widx,
    input  logic [7:0] wdata,
    input  logic [2:0] ridx,
    output logic [7:0] rdata
);

    logic [7:0] rd_arr [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_byte
            logic [7:0] byte_q;
            logic [7:0] byte_d;

            always_comb begin
                byte_d = byte_q;
                if (we && (widx == 3'(gi))) begin
                    byte_d = wdata;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    byte_q <= '0;
                end else begin
                    byte_q <= byte_d;
                end
            end

            assign rd_arr[gi] = byte_q;
        end
    endgenerate

    assign rdata = rd_arr[ridx];

endmodule

// File: rtl/mbyte_addsub_ctrl.sv
// Sequences an external 8-bit adder over A/B operand buffers, one byte per cycle,
// LSB first, into the R buffer. Optional signed-overflow flag: ADDSUB_OVF_EN.
module mbyte_addsub_ctrl #(
    parameter int MAX_BYTES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sub,
    input  logic [2:0] len_m1,
    input  logic       ld_valid,
    input  logic       ld_sel,
    input  logic [2:0] ld_idx,
    input  logic [7:0] ld_data,
    input  logic [2:0] rd_idx,
    output logic [7:0] rd_data,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_csel,
    output logic       add_sub_sel,
    output logic       add_cclear,
    output logic       add_eop,
    input  logic [7:0] add_s,
    input  logic       add_sign,
    input  logic       add_z,
    output logic       busy,
    output logic       done,
    output logic       res_sign,
    output logic       res_zero
`ifdef ADDSUB_OVF_EN
    ,
    output logic       res_ovf
`endif
);

    import addsub_pkg::*;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] len_q, len_d;
    logic       sub_q, sub_d;
    logic       zacc_q, zacc_d;
    logic       sign_q, sign_d;
    logic       zero_q, zero_d;
    // Snapshot of the operand byte overwritten by a load coinciding with start.
    logic       hold_vld_q, hold_vld_d;
    logic       hold_sel_q, hold_sel_d;
    logic [2:0] hold_idx_q, hold_idx_d;
    logic [7:0] hold_data_q, hold_data_d;
`ifdef ADDSUB_OVF_EN
    logic       ovf_q, ovf_d;
`endif

    logic [7:0] a_rd, b_rd, cur_a, cur_b;
    logic [2:0] op_idx;
    logic       ld_we, zacc_in;

    // Operand read ports address the load slot while idle so the old byte can be captured.
    assign op_idx = (state_q == RUN) ? cnt_q : ld_idx;
    assign ld_we  = ld_valid && (state_q == IDLE);

    addsub_byte_buf #(.DEPTH(MAX_BYTES)) u_buf_a (
        .clk(clk), .rst_n(rst_n), .we(ld_we && (ld_sel == SEL_A)),
        .widx(ld_idx), .wdata(ld_data), .ridx(op_idx), .rdata(a_rd)
    );

    addsub_byte_buf #(.DEPTH(MAX_BYTES)) u_buf_b (
        .clk(clk), .rst_n(rst_n), .we(ld_we && (ld_sel == SEL_B)),
        .widx(ld_idx), .wdata(ld_data), .ridx(op_idx), .rdata(b_rd)
    );

    addsub_byte_buf #(.DEPTH(MAX_BYTES)) u_buf_r (
        .clk(clk), .rst_n(rst_n), .we(state_q == RUN),
        .widx(cnt_q), .wdata(add_s), .ridx(rd_idx), .rdata(rd_data)
    );

    assign cur_a = (hold_vld_q && (hold_sel_q == SEL_A) && (hold_idx_q == cnt_q)) ? hold_data_q : a_rd;
    assign cur_b = (hold_vld_q && (hold_sel_q == SEL_B) && (hold_idx_q == cnt_q)) ? hold_data_q : b_rd;
    assign zacc_in = ((cnt_q == 3'd0) ? 1'b1 : zacc_q) & add_z;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        sub_d       = sub_q;
        zacc_d      = zacc_q;
        sign_d      = sign_q;
        zero_d      = zero_q;
        hold_vld_d  = hold_vld_q;
        hold_sel_d  = hold_sel_q;
        hold_idx_d  = hold_idx_q;
        hold_data_d = hold_data_q;
`ifdef ADDSUB_OVF_EN
        ovf_d       = ovf_q;
`endif
        add_a       = '0;
        add_b       = '0;
        add_csel    = 1'b0;
        add_sub_sel = 1'b0;
        add_cclear  = 1'b0;
        add_eop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    sub_d       = sub;
                    len_d       = len_m1;
                    cnt_d       = 3'd0;
                    hold_vld_d  = ld_valid;
                    hold_sel_d  = ld_sel;
                    hold_idx_d  = ld_idx;
                    hold_data_d = (ld_sel == SEL_B) ? b_rd : a_rd;
                end
            end
            RUN: begin
                add_a       = cur_a;
                add_b       = cur_b;
                add_csel    = (cnt_q != 3'd0);
                add_sub_sel = sub_q;
                add_cclear  = 1'b1;
                add_eop     = (cnt_q == len_q);
                zacc_d      = zacc_in;
                if (cnt_q == len_q) begin
                    state_d = DONE;
                    sign_d  = add_sign;
                    zero_d  = zacc_in;
`ifdef ADDSUB_OVF_EN
                    ovf_d   = sub_q ? ((cur_a[7] != cur_b[7]) && (add_s[7] != cur_a[7]))
                                    : ((cur_a[7] == cur_b[7]) && (add_s[7] != cur_a[7]));
`endif
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            sub_q       <= 1'b0;
            zacc_q      <= 1'b0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_sel_q  <= 1'b0;
            hold_idx_q  <= '0;
            hold_data_q <= '0;
`ifdef ADDSUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            sub_q       <= sub_d;
            zacc_q      <= zacc_d;
            sign_q      <= sign_d;
            zero_q      <= zero_d;
            hold_vld_q  <= hold_vld_d;
            hold_sel_q  <= hold_sel_d;
            hold_idx_q  <= hold_idx_d;
            hold_data_q <= hold_data_d;
`ifdef ADDSUB_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign res_sign = sign_q;
    assign res_zero = zero_q;
`ifdef ADDSUB_OVF_EN
    assign res_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_mbyte_addsub_ctrl.sv
// Bench for mbyte_addsub_ctrl: external byte adder model plus a whole-number
// reference model of the operand/result buffers.
module tb_mbyte_addsub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, sub = 1'b0, ld_valid = 1'b0, ld_sel = 1'b0;
    logic [2:0] len_m1 = '0, ld_idx = '0, rd_idx = '0;
    logic [7:0] ld_data = '0, rd_data;
    logic [7:0] add_a, add_b, add_s;
    logic       add_csel, add_sub_sel, add_cclear, add_eop, add_sign, add_z;
    logic       busy, done, res_sign, res_zero;
`ifdef ADDSUB_OVF_EN
    logic       res_ovf;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mbyte_addsub_ctrl #(.MAX_BYTES(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .len_m1(len_m1),
        .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_idx(ld_idx), .ld_data(ld_data),
        .rd_idx(rd_idx), .rd_data(rd_data),
        .add_a(add_a), .add_b(add_b), .add_csel(add_csel), .add_sub_sel(add_sub_sel),
        .add_cclear(add_cclear), .add_eop(add_eop),
        .add_s(add_s), .add_sign(add_sign), .add_z(add_z),
        .busy(busy), .done(done), .res_sign(res_sign), .res_zero(res_zero)
`ifdef ADDSUB_OVF_EN
        , .res_ovf(res_ovf)
`endif
    );

    // External adder: carry-in is sub on the first byte, else the carry stored last cycle.
    logic       carry_q = 1'b0;
    logic [8:0] sum9;
    always_comb begin
        sum9 = {1'b0, add_a} + {1'b0, (add_sub_sel ? ~add_b : add_b)}
             + {8'd0, (add_csel ? carry_q : add_sub_sel)};
    end
    assign add_s    = sum9[7:0];
    assign add_sign = sum9[7];
    assign add_z    = (sum9[7:0] == 8'd0);
    always @(posedge clk) if (add_cclear) carry_q <= sum9[8];

    // Reference model
    logic [7:0] ma [8];
    logic [7:0] mb [8];
    logic [7:0] mr [8];
    logic [7:0] exp_r [8];
    logic [7:0] obs_r [8];
    logic       exp_sign, exp_zero, exp_ovf;
    logic       held_sign = 1'b0, held_zero = 1'b0;

    int         op_lat;
    logic [7:0] op_csel, op_eop, op_cclr, op_ssel;
    logic       op_busy_run, op_done_busy, op_after_done, op_after_busy;

    function automatic void compute(input bit s, input int l);
        logic [63:0] a, b, res, mask;
        int n;
        n = l + 1;
        a = '0;
        b = '0;
        for (int i = 0; i < n; i++) begin
            a[8*i +: 8] = ma[i];
            b[8*i +: 8] = mb[i];
        end
        res  = s ? (a - b) : (a + b);
        mask = (n == 8) ? {64{1'b1}} : ((64'd1 << (8 * n)) - 64'd1);
        for (int i = 0; i < 8; i++) exp_r[i] = (i < n) ? res[8*i +: 8] : mr[i];
        exp_sign = res[8*n - 1];
        exp_zero = ((res & mask) == 64'd0);
        if (s) exp_ovf = (a[8*n-1] != b[8*n-1]) && (res[8*n-1] != a[8*n-1]);
        else   exp_ovf = (a[8*n-1] == b[8*n-1]) && (res[8*n-1] != a[8*n-1]);
    endfunction

    function automatic void commit();
        for (int i = 0; i < 8; i++) mr[i] = exp_r[i];
        held_sign = exp_sign;
        held_zero = exp_zero;
    endfunction

    task automatic load_byte(input logic sel, input logic [2:0] idx, input logic [7:0] data);
        @(negedge clk);
        ld_valid = 1'b1; ld_sel = sel; ld_idx = idx; ld_data = data;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        if (sel) mb[idx] = data; else ma[idx] = data;
    endtask

    task automatic load_operands(input logic [63:0] a, input logic [63:0] b);
        for (int i = 0; i < 8; i++) begin
            load_byte(1'b0, 3'(i), a[8*i +: 8]);
            load_byte(1'b1, 3'(i), b[8*i +: 8]);
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i);
            #1;
            obs_r[i] = rd_data;
        end
    endtask

    task automatic run_op(input bit s, input logic [2:0] l, input bit noise,
                          input bit cl, input logic csel_in, input logic [2:0] cidx,
                          input logic [7:0] cdata);
        int k;
        @(negedge clk);
        start = 1'b1; sub = s; len_m1 = l;
        ld_valid = cl; ld_sel = csel_in; ld_idx = cidx; ld_data = cdata;
        @(posedge clk); #1;
        start = 1'b0; ld_valid = 1'b0;
        op_lat = -1; op_csel = '0; op_eop = '0; op_cclr = '0; op_ssel = '0;
        op_busy_run = 1'b1;
        k = 0;
        for (int c = 2; c <= 24; c++) begin
            if (k < 8) begin
                op_csel[k] = add_csel;
                op_eop[k]  = add_eop;
                op_cclr[k] = add_cclear;
                op_ssel[k] = add_sub_sel;
            end
            k++;
            if (busy !== 1'b1) op_busy_run = 1'b0;
            if (noise) begin
                start = 1'($urandom); sub = ~s; len_m1 = 3'($urandom);
                ld_valid = 1'b1; ld_sel = 1'($urandom);
                ld_idx = 3'($urandom); ld_data = 8'($urandom);
            end
            @(posedge clk); #1;
            if (done === 1'b1) begin
                op_lat = c;
                break;
            end
        end
        start = 1'b0; ld_valid = 1'b0; sub = s;
        op_done_busy = busy;
        @(posedge clk); #1;
        op_after_done = done;
        op_after_busy = busy;
        $display("op sub=%0d len_m1=%0d noise=%0d concurrent_load=%0d latency=%0d", s, l, noise, cl, op_lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        read_all();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs_r[i] !== 8'h00) begin
                failures++;
                $display("FAIL reset_r[%0d] got=%h exp=00", i, obs_r[i]);
            end
        end
        checks++;
        if ({busy, done, res_sign, res_zero, add_csel, add_sub_sel, add_cclear, add_eop} !== 8'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000000",
                     {busy, done, res_sign, res_zero, add_csel, add_sub_sel, add_cclear, add_eop});
        end
        checks++;
        if ({add_a, add_b} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_add_ab got=%h exp=0000", {add_a, add_b});
        end
        for (int i = 0; i < 8; i++) begin ma[i] = 0; mb[i] = 0; mr[i] = 0; end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, add_cclear} !== 3'b000) begin
            failures++;
            $display("FAIL idle_ctrl got=%b exp=000", {busy, done, add_cclear});
        end
    endtask

    task automatic test_directed();
        logic [63:0] ta [4] = '{64'h00FF, 64'h0000, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF};
        logic [63:0] tb [4] = '{64'h0001, 64'h0001, 64'h1234, 64'h0000_0000_0000_0001};
        bit          ts [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int          tl [4] = '{1, 1, 1, 7};
        logic [63:0] tv [4] = '{64'h0100, 64'hFFFF, 64'h0000, 64'h0};
        logic        tz [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic        tg [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0]  mask;
        for (int c = 0; c < 4; c++) begin
            load_operands(ta[c], tb[c]);
            compute(ts[c], tl[c]);
            run_op(ts[c], 3'(tl[c]), 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
            commit();
            read_all();
            mask = 8'((9'd1 << (tl[c] + 1)) - 9'd1);
            checks++;
            if (op_lat !== tl[c] + 2) begin
                failures++;
                $display("FAIL dir%0d_latency got=%0d exp=%0d", c, op_lat, tl[c] + 2);
            end
            checks++;
            if ({op_csel, op_eop, op_cclr, op_ssel} !==
                {mask & 8'hFE, 8'(9'd1 << tl[c]), mask, (ts[c] ? mask : 8'h00)}) begin
                failures++;
                $display("FAIL dir%0d_adder_ctrl csel=%b eop=%b cclr=%b ssel=%b", c, op_csel, op_eop, op_cclr, op_ssel);
            end
            for (int i = 0; i <= tl[c]; i++) begin
                checks++;
                if (obs_r[i] !== tv[c][8*i +: 8]) begin
                    failures++;
                    $display("FAIL dir%0d_r[%0d] got=%h exp=%h", c, i, obs_r[i], tv[c][8*i +: 8]);
                end
            end
            checks++;
            if ({res_sign, res_zero} !== {tg[c], tz[c]}) begin
                failures++;
                $display("FAIL dir%0d_flags sign_zero got=%b%b exp=%b%b", c, res_sign, res_zero, tg[c], tz[c]);
            end
            checks++;
            if ({op_busy_run, op_done_busy, op_after_done, op_after_busy} !== 4'b1100) begin
                failures++;
                $display("FAIL dir%0d_busy_done got=%b exp=1100", c,
                         {op_busy_run, op_done_busy, op_after_done, op_after_busy});
            end
        end
    endtask

    task automatic test_random(input int n_ops, input bit noise);
        bit         s;
        int         l;
        for (int t = 0; t < n_ops; t++) begin
            for (int j = 0; j < int'($urandom_range(1, 6)); j++)
                load_byte(1'($urandom), 3'($urandom), 8'($urandom));
            s = 1'($urandom);
            l = $urandom_range(0, 7);
            compute(s, l);
            run_op(s, 3'(l), noise, 1'b0, 1'b0, 3'd0, 8'd0);
            commit();
            read_all();
            checks++;
            if (op_lat !== l + 2) begin
                failures++;
                $display("FAIL rnd%0d_latency got=%0d exp=%0d", t, op_lat, l + 2);
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_r[i] !== exp_r[i]) begin
                    failures++;
                    $display("FAIL rnd%0d_r[%0d] got=%h exp=%h noise=%0d", t, i, obs_r[i], exp_r[i], noise);
                end
            end
            checks++;
            if ({res_sign, res_zero} !== {held_sign, held_zero}) begin
                failures++;
                $display("FAIL rnd%0d_flags got=%b%b exp=%b%b", t, res_sign, res_zero, held_sign, held_zero);
            end
`ifdef ADDSUB_OVF_EN
            checks++;
            if (res_ovf !== exp_ovf) begin
                failures++;
                $display("FAIL rnd%0d_ovf got=%b exp=%b", t, res_ovf, exp_ovf);
            end
`endif
            // Flags must hold while idle.
            repeat (2) @(posedge clk);
            #1;
            checks++;
            if ({res_sign, res_zero, done} !== {held_sign, held_zero, 1'b0}) begin
                failures++;
                $display("FAIL rnd%0d_hold got=%b%b%b exp=%b%b0", t, res_sign, res_zero, done, held_sign, held_zero);
            end
        end
    endtask

    task automatic test_load_with_start();
        logic       sel;
        logic [2:0] idx;
        logic [7:0] data;
        int         l;
        for (int t = 0; t < 4; t++) begin
            load_operands({$urandom, $urandom}, {$urandom, $urandom});
            l    = $urandom_range(0, 7);
            sel  = 1'($urandom);
            idx  = 3'($urandom_range(0, l));
            data = 8'($urandom);
            compute(1'b0, l);
            run_op(1'b0, 3'(l), 1'b0, 1'b1, sel, idx, data);
            commit();
            if (sel) mb[idx] = data; else ma[idx] = data;
            read_all();
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_r[i] !== exp_r[i]) begin
                    failures++;
                    $display("FAIL ldstart%0d_old_r[%0d] got=%h exp=%h", t, i, obs_r[i], exp_r[i]);
                end
            end
            compute(1'b1, l);
            run_op(1'b1, 3'(l), 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
            commit();
            read_all();
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_r[i] !== exp_r[i]) begin
                    failures++;
                    $display("FAIL ldstart%0d_new_r[%0d] got=%h exp=%h", t, i, obs_r[i], exp_r[i]);
                end
            end
        end
    endtask

    task automatic test_midrun_reset();
        int saw_done;
        load_operands(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444);
        @(negedge clk);
        start = 1'b1; sub = 1'b0; len_m1 = 3'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        read_all();
        checks++;
        if ({busy, done, res_sign, res_zero, add_cclear, add_eop} !== 6'b0) begin
            failures++;
            $display("FAIL midrst_ctrl got=%b exp=000000", {busy, done, res_sign, res_zero, add_cclear, add_eop});
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs_r[i] !== 8'h00) begin
                failures++;
                $display("FAIL midrst_r[%0d] got=%h exp=00", i, obs_r[i]);
            end
            ma[i] = 0; mb[i] = 0; mr[i] = 0;
        end
        held_sign = 1'b0; held_zero = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) saw_done++;
        end
        checks++;
        if (saw_done !== 0) begin
            failures++;
            $display("FAIL midrst_no_done got=%0d exp=0", saw_done);
        end
        load_operands(64'h0000_0000_0000_80FF, 64'h0000_0000_0000_0001);
        compute(1'b0, 1);
        run_op(1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        commit();
        read_all();
        checks++;
        if ({obs_r[1], obs_r[0], res_sign, op_lat} !== {exp_r[1], exp_r[0], exp_sign, 32'sd3}) begin
            failures++;
            $display("FAIL midrst_after got=%h%h sign=%b lat=%0d exp=%h%h sign=%b lat=3",
                     obs_r[1], obs_r[0], res_sign, op_lat, exp_r[1], exp_r[0], exp_sign);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(20, 1'b0);
        test_random(8, 1'b1);
        test_load_with_start();
        test_midrun_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
